// File: rtl/sha2_t1_pipe.sv
// SHA-2 T1 datapath (H + Sigma1(E) + Ch(E,F,G) + Ki + Wi) for SHA-256/SHA-512,
// pipelined over 1..3 register stages with a full-backpressure valid/ready chain.
module sha2_t1_pipe #(
   parameter int WORD   = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WORD-1:0]  in_E,
   input  logic [WORD-1:0]  in_F,
   input  logic [WORD-1:0]  in_G,
   input  logic [WORD-1:0]  in_H,
   input  logic [WORD-1:0]  in_Ki,
   input  logic [WORD-1:0]  in_Wi,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WORD-1:0]  func,
   output logic [TAG_W-1:0] out_tag
);

   generate
      if (WORD != 32 && WORD != 64) begin : g_bad_word
         $error("sha2_t1_pipe: WORD must be 32 or 64, got %0d", WORD);
      end
      if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
         $error("sha2_t1_pipe: STAGES must be 1..3, got %0d", STAGES);
      end
   endgenerate

   localparam int ROT_A = (WORD == 64) ? 14 : 6;
   localparam int ROT_B = (WORD == 64) ? 18 : 11;
   localparam int ROT_C = (WORD == 64) ? 41 : 25;

   function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
      return (x >> n) | (x << (WORD - n));
   endfunction

   logic [WORD-1:0] sig1_c, ch_c, hk_c;

   assign sig1_c = rotr(in_E, ROT_A) ^ rotr(in_E, ROT_B) ^ rotr(in_E, ROT_C);
   assign ch_c   = (in_E & in_F) ^ (~in_E & in_G);
   assign hk_c   = in_H + in_Ki;

   // Handshake: a transfer happens on any edge where valid & ready are both high.
   // Stage k is ready when it is empty or some stage at or after it can move, so
   // a stage is blocked only if it and every stage downstream is full while
   // out_ready is low. Bubbles therefore collapse, and in_ready depends
   // combinationally on out_ready.
   logic [STAGES-1:0] v, vin, rdy, load;
   logic              full;

   always_comb begin
      full   = 1'b0;
      vin    = '0;
      rdy    = '0;
      vin[0] = in_valid;
      for (int k = 1; k < STAGES; k++) vin[k] = v[k-1];
      for (int k = 0; k < STAGES; k++) begin
         full = 1'b1;
         for (int j = k; j < STAGES; j++) full = full & v[j];
         rdy[k] = out_ready | ~full;
      end
      load = rdy & vin;
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[STAGES-1];

   logic [TAG_W-1:0] tag_r [STAGES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v <= '0;
         for (int k = 0; k < STAGES; k++) tag_r[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) v[k] <= vin[k];
         end
         if (load[0]) tag_r[0] <= in_tag;
         for (int k = 1; k < STAGES; k++) begin
            if (load[k]) tag_r[k] <= tag_r[k-1];
         end
      end
   end

   assign out_tag = tag_r[STAGES-1];

   logic [WORD-1:0] func_r;

   generate
      if (STAGES == 3) begin : g_s3
         logic [WORD-1:0] sig1_r, ch_r, hk_r, w_r, sa_r, sb_r;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sig1_r <= '0;
               ch_r   <= '0;
               hk_r   <= '0;
               w_r    <= '0;
               sa_r   <= '0;
               sb_r   <= '0;
               func_r <= '0;
            end else begin
               if (load[0]) begin
                  sig1_r <= sig1_c;
                  ch_r   <= ch_c;
                  hk_r   <= hk_c;
                  w_r    <= in_Wi;
               end
               if (load[1]) begin
                  sa_r <= sig1_r + ch_r;
                  sb_r <= hk_r + w_r;
               end
               if (load[2]) func_r <= sa_r + sb_r;
            end
         end
      end else if (STAGES == 2) begin : g_s2
         logic [WORD-1:0] sig1_r, ch_r, hk_r, w_r;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sig1_r <= '0;
               ch_r   <= '0;
               hk_r   <= '0;
               w_r    <= '0;
               func_r <= '0;
            end else begin
               if (load[0]) begin
                  sig1_r <= sig1_c;
                  ch_r   <= ch_c;
                  hk_r   <= hk_c;
                  w_r    <= in_Wi;
               end
               if (load[1]) func_r <= (sig1_r + ch_r) + (hk_r + w_r);
            end
         end
      end else begin : g_s1
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               func_r <= '0;
            end else if (load[0]) begin
               func_r <= (sig1_c + ch_c) + (hk_c + in_Wi);
            end
         end
      end
   endgenerate

   assign func = func_r;

endmodule
